// File: rtl/uart_cmd_dispatch_if.sv
// Byte-stream and module-bus signal bundle for uart_cmd_dispatch.
// The slave modport is the dispatcher; the master modport is the UART/bus side.
interface uart_cmd_dispatch_if #(
    parameter int DATA_BYTES = 3,
    parameter int ADDR_W     = 2,
    parameter int N_MOD      = 6
);
    logic [7:0]              rx_data;
    logic                    rx_valid;
    logic [7:0]              tx_data;
    logic                    tx_valid;
    logic                    tx_ready;
    logic [8*DATA_BYTES-1:0] D;
    logic [ADDR_W-1:0]       Adress;
    logic [N_MOD-1:0]        Mod_SEL;
    logic                    TRP;
    logic                    busy;
    logic [7:0]              err_cnt;

    modport slave (
        input  rx_data, rx_valid, tx_ready,
        output tx_data, tx_valid, D, Adress, Mod_SEL, TRP, busy, err_cnt
    );

    modport master (
        output rx_data, rx_valid, tx_ready,
        input  tx_data, tx_valid, D, Adress, Mod_SEL, TRP, busy, err_cnt
    );
endinterface

// File: rtl/uart_cmd_dispatch.sv
// Framed UART command parser: validates HDR/MOD/ADDR/DATA/CSUM frames, drives the
// parallel module bus with setup and strobe timing, and answers each frame with ACK/NAK.
module uart_cmd_dispatch #(
    parameter int         DATA_BYTES  = 3,
    parameter int         ADDR_W      = 2,
    parameter int         N_MOD       = 6,
    parameter int         SETUP_CYC   = 2,
    parameter int         TRP_CYC     = 4,
    parameter int         TIMEOUT_CYC = 50000,
    parameter logic [7:0] HDR         = 8'hA5,
    parameter logic [7:0] ACK         = 8'h06,
    parameter logic [7:0] NAK         = 8'h15
) (
    input  logic                sys_clk,
    input  logic                sys_rst,
    uart_cmd_dispatch_if.slave  bus
);

    localparam int DW      = 8 * DATA_BYTES;
    localparam int BC_W    = (DATA_BYTES > 1) ? $clog2(DATA_BYTES) : 1;
    localparam int CNT_MAX = (SETUP_CYC > TRP_CYC) ? SETUP_CYC : TRP_CYC;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam int TO_W    = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_MOD   = 3'd1,
        S_ADDR  = 3'd2,
        S_DATA  = 3'd3,
        S_CSUM  = 3'd4,
        S_SETUP = 3'd5,
        S_PULSE = 3'd6,
        S_REPLY = 3'd7
    } state_t;

    function automatic logic [7:0] f_csum_add(input logic [7:0] acc, input logic [7:0] b);
        return acc + b;
    endfunction

    state_t            r_state;
    state_t            w_state_nxt;

    logic [7:0]        r_mod;
    logic [7:0]        r_addr;
    logic [7:0]        r_pay [DATA_BYTES];
    logic [BC_W-1:0]   r_byte_cnt;
    logic [7:0]        r_sum;
    logic [CNT_W-1:0]  r_cnt;
    logic [TO_W-1:0]   r_to_cnt;

    logic [DW-1:0]     r_d;
    logic [ADDR_W-1:0] r_adress;
    logic [N_MOD-1:0]  r_mod_sel;
    logic              r_trp;
    logic              r_tx_valid;
    logic [7:0]        r_tx_data;
    logic              r_busy;
    logic [7:0]        r_err_cnt;

    logic              w_in_frame;
    logic              w_timeout;
    logic              w_mod_ok;
    logic              w_addr_ok;
    logic              w_frame_ok;
    logic              w_accept;
    logic              w_reject;
    logic [DW-1:0]     w_payload;
    logic [N_MOD-1:0]  w_sel;

    // Frame checks, payload assembly (DATA[0] is the MSB byte) and next-state decode.
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_reject    = 1'b0;
        w_payload   = '0;
        for (int i = 0; i < DATA_BYTES; i++) begin
            w_payload[8*(DATA_BYTES-1-i) +: 8] = r_pay[i];
        end
        w_sel      = N_MOD'(1'b1) << r_mod[2:0];
        w_mod_ok   = (r_mod < 8'(N_MOD));
        w_addr_ok  = ((r_addr >> ADDR_W) == 8'h00);
        w_frame_ok = (bus.rx_data == r_sum) && w_mod_ok && w_addr_ok;
        w_in_frame = (r_state == S_MOD) || (r_state == S_ADDR) ||
                     (r_state == S_DATA) || (r_state == S_CSUM);
        w_timeout  = w_in_frame && !bus.rx_valid && (r_to_cnt == TO_W'(TIMEOUT_CYC - 1));

        case (r_state)
            S_IDLE: begin
                if (bus.rx_valid && (bus.rx_data == HDR)) begin
                    w_state_nxt = S_MOD;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_MOD, S_ADDR: begin
                if (bus.rx_valid) begin
                    w_state_nxt = (r_state == S_MOD) ? S_ADDR : S_DATA;
                end else if (w_timeout) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_state_nxt = r_state;
                end
            end
            S_DATA: begin
                if (bus.rx_valid && (r_byte_cnt == BC_W'(DATA_BYTES - 1))) begin
                    w_state_nxt = S_CSUM;
                end else if (w_timeout) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_state_nxt = S_DATA;
                end
            end
            S_CSUM: begin
                if (bus.rx_valid) begin
                    w_accept    = w_frame_ok;
                    w_reject    = !w_frame_ok;
                    w_state_nxt = w_frame_ok ? S_SETUP : S_REPLY;
                end else if (w_timeout) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_state_nxt = S_CSUM;
                end
            end
            S_SETUP: begin
                if (r_cnt == CNT_W'(SETUP_CYC - 1)) begin
                    w_state_nxt = S_PULSE;
                end else begin
                    w_state_nxt = S_SETUP;
                end
            end
            S_PULSE: begin
                if (r_cnt == CNT_W'(TRP_CYC - 1)) begin
                    w_state_nxt = S_REPLY;
                end else begin
                    w_state_nxt = S_PULSE;
                end
            end
            S_REPLY: begin
                if (bus.tx_ready) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_state_nxt = S_REPLY;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Frame capture, phase/timeout counters and registered bus/reply outputs.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_mod      <= 8'h00;
            r_addr     <= 8'h00;
            for (int i = 0; i < DATA_BYTES; i++) begin
                r_pay[i] <= 8'h00;
            end
            r_byte_cnt <= '0;
            r_sum      <= 8'h00;
            r_cnt      <= '0;
            r_to_cnt   <= '0;
            r_d        <= '0;
            r_adress   <= '0;
            r_mod_sel  <= '0;
            r_trp      <= 1'b0;
            r_tx_valid <= 1'b0;
            r_tx_data  <= 8'h00;
            r_busy     <= 1'b0;
            r_err_cnt  <= 8'h00;
        end else begin
            r_busy     <= (w_state_nxt != S_IDLE);
            r_trp      <= (w_state_nxt == S_PULSE);
            r_tx_valid <= (w_state_nxt == S_REPLY);

            if (bus.rx_valid) begin
                case (r_state)
                    S_MOD: begin
                        r_mod <= bus.rx_data;
                        r_sum <= bus.rx_data;
                    end
                    S_ADDR: begin
                        r_addr     <= bus.rx_data;
                        r_sum      <= f_csum_add(r_sum, bus.rx_data);
                        r_byte_cnt <= '0;
                    end
                    S_DATA: begin
                        r_pay[r_byte_cnt] <= bus.rx_data;
                        r_sum             <= f_csum_add(r_sum, bus.rx_data);
                        r_byte_cnt        <= r_byte_cnt + BC_W'(1);
                    end
                    default: begin
                    end
                endcase
            end

            // Idle-gap counter only ticks while a frame is being collected.
            if (w_in_frame && !bus.rx_valid && !w_timeout) begin
                r_to_cnt <= r_to_cnt + TO_W'(1);
            end else begin
                r_to_cnt <= '0;
            end

            if (((r_state == S_SETUP) || (r_state == S_PULSE)) && (w_state_nxt == r_state)) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end else begin
                r_cnt <= '0;
            end

            if (w_accept) begin
                r_d       <= w_payload;
                r_adress  <= r_addr[ADDR_W-1:0];
                r_mod_sel <= w_sel;
                r_tx_data <= ACK;
            end else if (w_reject) begin
                r_tx_data <= NAK;
            end

            if ((w_reject || w_timeout) && (r_err_cnt != 8'hFF)) begin
                r_err_cnt <= r_err_cnt + 8'h01;
            end
        end
    end

    assign bus.D        = r_d;
    assign bus.Adress   = r_adress;
    assign bus.Mod_SEL  = r_mod_sel;
    assign bus.TRP      = r_trp;
    assign bus.tx_valid = r_tx_valid;
    assign bus.tx_data  = r_tx_data;
    assign bus.busy     = r_busy;
    assign bus.err_cnt  = r_err_cnt;

endmodule

// File: tb/tb_uart_cmd_dispatch.sv
// Directed scoreboard bench for uart_cmd_dispatch: bus writes and replies are queued
// when frames are sent and checked when TRP rises / the reply handshake happens.
module tb_uart_cmd_dispatch;

    localparam int T_TO = 200;

    logic clk;
    logic rst;

    uart_cmd_dispatch_if #(.DATA_BYTES(3), .ADDR_W(2), .N_MOD(6)) ifc ();

    uart_cmd_dispatch #(
        .DATA_BYTES(3), .ADDR_W(2), .N_MOD(6), .SETUP_CYC(2), .TRP_CYC(4),
        .TIMEOUT_CYC(T_TO), .HDR(8'hA5), .ACK(8'h06), .NAK(8'h15)
    ) dut (
        .sys_clk (clk),
        .sys_rst (rst),
        .bus     (ifc.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_cmp;
    int          n_bad;
    int          cyc;
    int          csum_cyc;
    int          trp_len;
    int          exp_err;
    logic        prev_trp;
    logic [31:0] q_bus [$];
    logic [7:0]  q_tx  [$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: check a reply handshake about to complete, then advance to the negedge and watch TRP.
    task automatic tick();
        logic [31:0] eb;
        logic [7:0]  et;
        if (ifc.tx_valid === 1'b1 && ifc.tx_ready === 1'b1) begin
            chk("tx_expected", q_tx.size() != 0, 1);
            if (q_tx.size() != 0) begin
                et = q_tx.pop_front();
                chk("tx_data", ifc.tx_data, et);
            end
        end
        @(negedge clk);
        cyc++;
        if (rst) begin
            prev_trp = 1'b0;
            trp_len  = 0;
        end else begin
            if (ifc.TRP === 1'b1 && !prev_trp) begin
                chk("trp_expected", q_bus.size() != 0, 1);
                if (q_bus.size() != 0) begin
                    eb = q_bus.pop_front();
                    chk("bus_value", {ifc.D, ifc.Adress, ifc.Mod_SEL}, eb);
                end
                chk("trp_latency", cyc - csum_cyc, 3);
            end
            if (ifc.TRP === 1'b1) begin
                trp_len++;
            end else if (prev_trp) begin
                chk("trp_width", trp_len, 4);
                trp_len = 0;
            end
            prev_trp = (ifc.TRP === 1'b1);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        ifc.rx_data  = b;
        ifc.rx_valid = 1'b1;
        tick();
        ifc.rx_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] m, input logic [7:0] a, input logic [23:0] d,
                              input logic [7:0] cs, input int gap);
        logic [7:0] sum;
        logic [5:0] sel;
        logic       ok;
        sum = m + a + d[23:16] + d[15:8] + d[7:0];
        ok  = (sum == cs) && (m < 8'd6) && (a < 8'd4);
        send_byte(8'hA5);
        send_byte(m);
        repeat (gap) tick();
        send_byte(a);
        send_byte(d[23:16]);
        send_byte(d[15:8]);
        send_byte(d[7:0]);
        if (ok) begin
            sel = 6'b000001 << m[2:0];
            q_bus.push_back({d, a[1:0], sel});
            q_tx.push_back(8'h06);
        end else begin
            q_tx.push_back(8'h15);
            if (exp_err < 255) exp_err++;
        end
        csum_cyc = cyc;
        send_byte(cs);
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (ifc.busy === 1'b1 && n < 100) begin
            tick();
            n++;
        end
        chk(tag, ifc.busy, 0);
    endtask

    initial begin
        int n;
        n_cmp = 0; n_bad = 0; cyc = 0; csum_cyc = 0; trp_len = 0; exp_err = 0; prev_trp = 1'b0;
        rst = 1'b1;
        ifc.rx_data = 8'h00; ifc.rx_valid = 1'b0; ifc.tx_ready = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        tick();

        chk("rst_D", ifc.D, 0);
        chk("rst_Adress", ifc.Adress, 0);
        chk("rst_Mod_SEL", ifc.Mod_SEL, 0);
        chk("rst_TRP", ifc.TRP, 0);
        chk("rst_tx_valid", ifc.tx_valid, 0);
        chk("rst_tx_data", ifc.tx_data, 0);
        chk("rst_busy", ifc.busy, 0);
        chk("rst_err_cnt", ifc.err_cnt, 0);

        // Good frame, then bad checksum, then out-of-range module and address.
        send_frame(8'h02, 8'h01, 24'h123456, 8'h9F, 0);
        wait_idle("t1_idle");
        chk("t1_err", ifc.err_cnt, exp_err);
        send_frame(8'h02, 8'h01, 24'h123456, 8'h9E, 0);
        wait_idle("t2_idle");
        chk("t2_err", ifc.err_cnt, exp_err);
        chk("t2_D_hold", ifc.D, 24'h123456);
        chk("t2_Adress_hold", ifc.Adress, 2'b01);
        chk("t2_Mod_SEL_hold", ifc.Mod_SEL, 6'b000100);
        send_frame(8'h06, 8'h00, 24'h000000, 8'h06, 0);
        wait_idle("t3a_idle");
        send_frame(8'h00, 8'h04, 24'h000000, 8'h04, 0);
        wait_idle("t3b_idle");
        chk("t3_err", ifc.err_cnt, exp_err);

        // Timeout: exactly T_TO idle cycles inside a frame aborts it.
        send_byte(8'hA5);
        send_byte(8'h01);
        repeat (T_TO - 1) tick();
        chk("t4_busy_before_to", ifc.busy, 1);
        tick();
        chk("t4_busy_after_to", ifc.busy, 0);
        exp_err++;
        chk("t4_err", ifc.err_cnt, exp_err);
        send_frame(8'h03, 8'h02, 24'hABCDEF, 8'h6C, T_TO - 1);
        wait_idle("t4_good_idle");
        chk("t4_good_D", ifc.D, 24'hABCDEF);

        // Back-pressure in REPLY with bytes injected during PULSE and REPLY.
        ifc.tx_ready = 1'b0;
        send_frame(8'h04, 8'h03, 24'h112233, 8'h6D, 0);
        n = 0;
        while (ifc.TRP !== 1'b1 && n < 20) begin tick(); n++; end
        chk("t5_trp_seen", ifc.TRP, 1);
        send_byte(8'hA5);
        send_byte(8'h00);
        n = 0;
        while (ifc.tx_valid !== 1'b1 && n < 20) begin tick(); n++; end
        chk("t5_reply_seen", ifc.tx_valid, 1);
        send_byte(8'hA5);
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("t5_tx_valid_held", ifc.tx_valid, 1);
            chk("t5_tx_data_held", ifc.tx_data, 8'h06);
        end
        ifc.tx_ready = 1'b1;
        tick();
        chk("t5_tx_valid_drop", ifc.tx_valid, 0);
        chk("t5_busy_drop", ifc.busy, 0);
        tick();
        chk("t5_no_new_frame", ifc.busy, 0);

        // Reset during the strobe.
        send_frame(8'h05, 8'h00, 24'h010203, 8'h0B, 0);
        n = 0;
        while (ifc.TRP !== 1'b1 && n < 20) begin tick(); n++; end
        chk("t5r_trp_seen", ifc.TRP, 1);
        rst = 1'b1;
        tick();
        void'(q_tx.pop_back());
        exp_err = 0;
        chk("t5r_TRP", ifc.TRP, 0);
        chk("t5r_D", ifc.D, 0);
        chk("t5r_Adress", ifc.Adress, 0);
        chk("t5r_Mod_SEL", ifc.Mod_SEL, 0);
        chk("t5r_tx_valid", ifc.tx_valid, 0);
        chk("t5r_tx_data", ifc.tx_data, 0);
        chk("t5r_busy", ifc.busy, 0);
        chk("t5r_err", ifc.err_cnt, 0);
        rst = 1'b0;
        tick();
        chk("t5r_idle_after", ifc.busy, 0);

        // Stray bytes in IDLE, then error counter saturation.
        send_byte(8'h00);
        chk("t6_stray00_busy", ifc.busy, 0);
        send_byte(8'hFF);
        chk("t6_strayFF_busy", ifc.busy, 0);
        send_byte(8'h12);
        chk("t6_stray12_busy", ifc.busy, 0);
        chk("t6_stray_err", ifc.err_cnt, 0);
        for (int i = 0; i < 300; i++) begin
            send_frame(8'h00, 8'h00, 24'h000000, 8'h01, 0);
            wait_idle("t6_idle");
            if (i == 253 || i == 254) chk("t6_err_edge", ifc.err_cnt, exp_err);
        end
        chk("t6_err_sat", ifc.err_cnt, 8'hFF);
        chk("t6_D_hold", ifc.D, 24'hABCDEF ^ 24'hABCDEF);

        chk("end_bus_queue", q_bus.size(), 0);
        chk("end_tx_queue", q_tx.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
